// File: rtl/nina_unmask_check.sv
// Output-boundary unmasking for the 3-share, 3-lane NINA encoding: shares are
// recombined one per cycle, lane consistency is checked and a sticky alarm kept.
module nina_unmask_check #(
    parameter int NBITS = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3*NBITS-1:0] port_c_0,
    input  logic [3*NBITS-1:0] port_c_1,
    input  logic [3*NBITS-1:0] port_c_2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NBITS-1:0]   out_data,
    output logic               out_fault,
    output logic               alarm,
    input  logic               alarm_clr
);

    localparam int W = 3 * NBITS;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ACC0 = 3'd1,
        ACC1 = 3'd2,
        ACC2 = 3'd3,
        RESP = 3'd4
    } state_t;

    // A codeword is inconsistent when any bit has lanes that disagree.
    function automatic logic lane_err(input logic [W-1:0] x);
        logic e;
        e = 1'b0;
        for (int b = 0; b < NBITS; b++) begin
            e = e | (x[3*b] != x[3*b+1]) | (x[3*b] != x[3*b+2]);
        end
        return e;
    endfunction

    function automatic logic [NBITS-1:0] lane0(input logic [W-1:0] x);
        logic [NBITS-1:0] d;
        d = {NBITS{1'b0}};
        for (int b = 0; b < NBITS; b++) begin
            d[b] = x[3*b];
        end
        return d;
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [W-1:0]     sh0_r;
    logic [W-1:0]     sh1_r;
    logic [W-1:0]     sh2_r;
    logic [W-1:0]     acc_r;
    logic             err_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             out_fault_r;
    logic [NBITS-1:0] out_data_r;
    logic             alarm_r;
    logic             accept_s;
    logic [W-1:0]     acc_fin_s;
    logic             fault_s;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_fault = out_fault_r;
    assign out_data  = out_data_r;
    assign alarm     = alarm_r;

    // Final recombination and fault decision, consumed on the ACC2 edge.
    always_comb begin
        accept_s  = in_valid && in_ready_r;
        acc_fin_s = acc_r ^ sh2_r;
        fault_s   = err_r | lane_err(sh2_r) | lane_err(acc_fin_s);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: one share consumed per cycle, then hold the result.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ACC0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACC0: state_nxt_s = ACC1;
            ACC1: state_nxt_s = ACC2;
            ACC2: state_nxt_s = RESP;
            RESP: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Share capture, sequential accumulation and registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh0_r       <= {W{1'b0}};
            sh1_r       <= {W{1'b0}};
            sh2_r       <= {W{1'b0}};
            acc_r       <= {W{1'b0}};
            err_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_fault_r <= 1'b0;
            out_data_r  <= {NBITS{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        sh0_r      <= port_c_0;
                        sh1_r      <= port_c_1;
                        sh2_r      <= port_c_2;
                        err_r      <= 1'b0;
                        in_ready_r <= 1'b0;
                    end
                end
                ACC0: begin
                    acc_r <= sh0_r;
                    err_r <= err_r | lane_err(sh0_r);
                end
                ACC1: begin
                    acc_r <= acc_r ^ sh1_r;
                    sh0_r <= {W{1'b0}};
                    err_r <= err_r | lane_err(sh1_r);
                end
                ACC2: begin
                    acc_r       <= acc_fin_s;
                    sh1_r       <= {W{1'b0}};
                    err_r       <= err_r | lane_err(sh2_r);
                    out_valid_r <= 1'b1;
                    out_fault_r <= fault_s;
                    out_data_r  <= fault_s ? {NBITS{1'b0}} : lane0(acc_fin_s);
                end
                RESP: begin
                    if (out_ready) begin
                        sh2_r       <= {W{1'b0}};
                        acc_r       <= {W{1'b0}};
                        out_valid_r <= 1'b0;
                        out_fault_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Sticky alarm; a new fault wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_r <= 1'b0;
        end else if ((state_r == ACC2) && fault_s) begin
            alarm_r <= 1'b1;
        end else if (alarm_clr) begin
            alarm_r <= 1'b0;
        end
    end

endmodule
